// File: rtl/hdmi_link_ctrl_if.sv
// Link-control signal bundle between the HDMI bring-up sequencer and the board-level
// PLL/CLKDIV/DVI_TX wiring. The master modport is the sequencer side.
interface hdmi_link_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             pll_lock;
    logic             pll_reset;
    logic             tx_rst_n;
    logic             link_up;
    logic [2:0]       state;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        input  enable, pll_lock,
        output pll_reset, tx_rst_n, link_up, state, timeout_cnt, loss_cnt
    );

    modport slave (
        output enable, pll_lock,
        input  pll_reset, tx_rst_n, link_up, state, timeout_cnt, loss_cnt
    );
endinterface

// File: rtl/hdmi_link_ctrl.sv
// HDMI TX bring-up sequencer: PLL reset pulse, qualified lock wait, settle, run, auto-recovery.
// Status counters exist only when HDMI_LINK_CTRL_STATUS_EN is defined; otherwise tied to 0.
module hdmi_link_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int SETTLE_CYCLES  = 2700,
    parameter int CNT_W          = 8
) (
    input  logic               clk_27mhz,
    input  logic               rst,
    hdmi_link_ctrl_if.master   bus
);
    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW    = $clog2(MAX_P);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, lock_s_q;
    logic            pll_reset_q, pll_reset_d;
    logic            tx_rst_n_q, tx_rst_n_d;
    logic            link_up_q, link_up_d;

    always_ff @(posedge clk_27mhz or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (bus.enable) state_d = PLL_RST;
            PLL_RST:   if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s_q)                             state_d = SETTLE;
                else if (cnt_q == CW'(LOCK_TIMEOUT - 1))  state_d = PLL_RST;
            end
            SETTLE: begin
                if (!lock_s_q)                            state_d = WAIT_LOCK;
                else if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = RUN;
            end
            RUN:       if (!lock_s_q) state_d = PLL_RST;
            default:   state_d = IDLE;
        endcase
        if (!bus.enable) state_d = IDLE;

        // The counter restarts on every state entry; IDLE and RUN have no interval to time.
        if (state_d != state_q || state_q == IDLE || state_q == RUN) cnt_d = '0;
        else                                                         cnt_d = cnt_q + CW'(1);

        pll_reset_d = (state_d == IDLE) || (state_d == PLL_RST);
        tx_rst_n_d  = (state_d == RUN);
        link_up_d   = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_27mhz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            tx_rst_n_q  <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= pll_reset_d;
            tx_rst_n_q  <= tx_rst_n_d;
            link_up_q   <= link_up_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.pll_reset = pll_reset_q;
    assign bus.tx_rst_n  = tx_rst_n_q;
    assign bus.link_up   = link_up_q;

`ifdef HDMI_LINK_CTRL_STATUS_EN
    logic             timeout_evt, loss_evt;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Forced IDLE (enable low) never lands in PLL_RST, so a dropped enable suppresses both events.
    always_comb begin
        timeout_evt   = (state_q == WAIT_LOCK) && (state_d == PLL_RST);
        loss_evt      = (state_q == RUN) && (state_d == PLL_RST);
        timeout_cnt_d = timeout_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        if (timeout_evt && !(&timeout_cnt_q)) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        if (loss_evt && !(&loss_cnt_q))       loss_cnt_d    = loss_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_27mhz or posedge rst) begin
        if (rst) begin
            timeout_cnt_q <= '0;
            loss_cnt_q    <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    assign bus.timeout_cnt = timeout_cnt_q;
    assign bus.loss_cnt    = loss_cnt_q;
`else
    assign bus.timeout_cnt = '0;
    assign bus.loss_cnt    = '0;
`endif
endmodule
